prm_edge_chk_seq: RTL and testbench

Parametrised, streaming successor to the per-pattern PRM obstacle-logic checkers. One hard-wired sum-of-products per obstacle set is replaced by a loadable occupancy table of 2^CODE_W bits. Each roadmap edge is streamed in as a sequence of configuration codes, every code is looked up in the table, and one collision verdict per edge is returned over a valid/ready result port. The block sits between the PRM edge sampler and the roadmap graph builder.

---
 rtl/prm_edge_chk_seq.sv | 191 +++++++++++++++++++
 tb/tb_prm_edge_chk_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_chk_seq.sv
// prm_edge_chk_seq
//   Streaming PRM edge collision checker. A loadable 2^CODE_W x 1 occupancy
//   table (1 = obstacle) replaces the per-pattern obstacle logic. Each edge
//   arrives as a stream of configuration codes. Every code is looked up in
//   the table, and one verdict per edge is returned over a valid/ready port.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   tbl_we/addr/wdata table write port; writes are accepted only while idle
//   mode_early        stop looking up after the first hit (sampled on beat 0)
//   smp_valid/ready   sample beat handshake
//   smp_code          configuration code to look up
//   smp_id            edge id (captured on the first beat)
//   smp_last          final beat of the edge
//   res_valid/ready   result handshake; res_* held while res_valid=1
//   res_id            edge id
//   res_mask          1 = at least one sample collided
//   res_count         samples looked up (saturating)
//   res_hits          colliding samples (saturating)
//   res_first         index of the first hit, 0 if none (saturating)
module prm_edge_chk_seq #(
  parameter int unsigned CODE_W = 15,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tbl_we,
  input  logic [CODE_W-1:0] tbl_addr,
  input  logic              tbl_wdata,
  input  logic              mode_early,
  input  logic              smp_valid,
  output logic              smp_ready,
  input  logic [CODE_W-1:0] smp_code,
  input  logic [ID_W-1:0]   smp_id,
  input  logic              smp_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ID_W-1:0]   res_id,
  output logic              res_mask,
  output logic [CNT_W-1:0]  res_count,
  output logic [CNT_W-1:0]  res_hits,
  output logic [CNT_W-1:0]  res_first
);

  localparam int unsigned DEPTH = 1 << CODE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // S_WAIT covers the single cycle in which the last beat's lookup returns.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              early_q, early_d;
  logic              mask_q, mask_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  hits_q, hits_d;
  logic [CNT_W-1:0]  first_q, first_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_data_q;

  logic              mem [DEPTH];
  logic              accept;
  logic              lookup_en;
  logic              tbl_wr_en;
  logic              stop_now;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    early_d   = early_q;
    mask_d    = mask_q;
    count_d   = count_q;
    hits_d    = hits_q;
    first_d   = first_q;
    lookup_en = 1'b0;
    tbl_wr_en = 1'b0;

    smp_ready = (state_q == S_IDLE) || (state_q == S_SCAN) || (state_q == S_DRAIN);
    accept    = smp_valid && smp_ready;
    // First hit in early mode; no edge reaching here has seen a prior hit,
    // because any earlier hit would already have moved us to DRAIN.
    stop_now  = early_q && rd_vld_q && rd_data_q;

    if (rd_vld_q) begin
      // count_q is the 0-based index of the returning sample.
      count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
      if (rd_data_q) begin
        mask_d = 1'b1;
        hits_d = (hits_q == CNT_MAX) ? hits_q : hits_q + 1'b1;
        if (!mask_q) begin
          first_d = count_q;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        tbl_wr_en = tbl_we;
        if (accept) begin
          id_d      = smp_id;
          early_d   = mode_early;
          mask_d    = 1'b0;
          count_d   = '0;
          hits_d    = '0;
          first_d   = '0;
          lookup_en = 1'b1;
          state_d   = smp_last ? S_WAIT : S_SCAN;
        end
      end
      S_SCAN: begin
        if (accept) begin
          // A beat accepted in the same cycle as the stopping hit is never
          // looked up, so nothing is left in flight once draining starts.
          lookup_en = !stop_now;
          if (smp_last) begin
            state_d = S_WAIT;
          end else if (stop_now) begin
            state_d = S_DRAIN;
          end
        end else if (stop_now) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept && smp_last) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_vld_d = lookup_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      early_q  <= 1'b0;
      mask_q   <= 1'b0;
      count_q  <= '0;
      hits_q   <= '0;
      first_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      early_q  <= early_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      hits_q   <= hits_d;
      first_q  <= first_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Occupancy table: contents are not reset, and reads are synchronous.
  always_ff @(posedge clk) begin
    if (tbl_wr_en) begin
      mem[tbl_addr] <= tbl_wdata;
    end
    if (lookup_en) begin
      rd_data_q <= mem[smp_code];
    end
  end

  assign res_valid = (state_q == S_RESULT);
  assign res_id    = id_q;
  assign res_mask  = mask_q;
  assign res_count = count_q;
  assign res_hits  = hits_q;
  assign res_first = first_q;

endmodule

// File: tb/tb_prm_edge_chk_seq.sv
module tb_prm_edge_chk_seq;

  localparam int unsigned CW = 15;
  localparam int unsigned IW = 8;
  localparam int unsigned NW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          tbl_we;
  logic [CW-1:0] tbl_addr;
  logic          tbl_wdata;
  logic          mode_early;
  logic          smp_valid;
  logic          smp_ready;
  logic [CW-1:0] smp_code;
  logic [IW-1:0] smp_id;
  logic          smp_last;
  logic          res_valid;
  logic          res_ready;
  logic [IW-1:0] res_id;
  logic          res_mask;
  logic [NW-1:0] res_count;
  logic [NW-1:0] res_hits;
  logic [NW-1:0] res_first;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  prm_edge_chk_seq #(.CODE_W(CW), .ID_W(IW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .mode_early(mode_early),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_code(smp_code),
    .smp_id(smp_id), .smp_last(smp_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_mask(res_mask), .res_count(res_count), .res_hits(res_hits),
    .res_first(res_first)
  );

  typedef struct {
    logic               early;
    logic [IW-1:0]      id;
    int unsigned        n;
    logic [3:0][CW-1:0] codes;
    logic               mask;
    logic [NW-1:0]      cnt;
    logic [NW-1:0]      hits;
    logic [NW-1:0]      first;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic twrite(input logic [CW-1:0] a, input logic d);
    tbl_we = 1'b1; tbl_addr = a; tbl_wdata = d;
    tick();
    tbl_we = 1'b0;
  endtask

  // Presents one beat and returns once it has been accepted (bounded wait).
  task automatic beat(input logic [CW-1:0] code, input logic [IW-1:0] id,
                      input logic last, output int stall);
    smp_valid = 1'b1; smp_code = code; smp_id = id; smp_last = last;
    stall = 0;
    while (!smp_ready && stall < 50) begin
      tick();
      stall++;
    end
    tick();
    smp_valid = 1'b0; smp_last = 1'b0;
  endtask

  // Called one cycle after the last beat was accepted.
  task automatic finish_edge(input string name, input logic [IW-1:0] id, input logic mask,
                             input logic [NW-1:0] cnt, input logic [NW-1:0] hits,
                             input logic [NW-1:0] first, input int hold);
    logic ok;
    check({name, " res_valid at t+1"}, res_valid, 1'b0);
    check({name, " smp_ready at t+1"}, smp_ready, 1'b0);
    tick();
    check({name, " res_valid at t+2"}, res_valid, 1'b1);
    check({name, " res_id"}, res_id, id);
    check({name, " res_mask"}, res_mask, mask);
    check({name, " res_count"}, res_count, cnt);
    check({name, " res_hits"}, res_hits, hits);
    check({name, " res_first"}, res_first, first);
    if (hold > 0) begin
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (!(res_valid === 1'b1 && smp_ready === 1'b0 && res_id === id &&
              res_mask === mask && res_count === cnt && res_hits === hits &&
              res_first === first)) ok = 1'b0;
      end
      check({name, " held stable under backpressure"}, ok, 1'b1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({name, " idle after accept"}, {res_valid, smp_ready}, 2'b01);
  endtask

  task automatic run_vec(input int idx, input int hold);
    int st;
    int stall_sum;
    string nm;
    nm = $sformatf("vec%0d", idx);
    stall_sum = 0;
    mode_early = vecs[idx].early;
    for (int i = 0; i < int'(vecs[idx].n); i++) begin
      beat(vecs[idx].codes[i], (i == 0) ? vecs[idx].id : ~vecs[idx].id,
           (i == int'(vecs[idx].n) - 1), st);
      stall_sum += st;
      // Only the first beat may sample the mode.
      mode_early = ~vecs[idx].early;
    end
    check({nm, " beats never stalled"}, stall_sum, 0);
    finish_edge(nm, vecs[idx].id, vecs[idx].mask, vecs[idx].cnt, vecs[idx].hits,
                vecs[idx].first, hold);
  endtask

  initial begin
    int st;
    rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = 1'b0; mode_early = 1'b0;
    smp_valid = 1'b0; smp_code = '0; smp_id = '0; smp_last = 1'b0; res_ready = 1'b0;

    //          early id     n  codes (beat3..beat0)                          mask cnt hits first
    vecs[0] = '{1'b0, 8'd5,  4, {15'h1234, 15'h0002, 15'h1234, 15'h0001}, 1'b1, 6'd4, 6'd2, 6'd1};
    vecs[1] = '{1'b1, 8'd6,  4, {15'h1234, 15'h0002, 15'h1234, 15'h0001}, 1'b1, 6'd2, 6'd1, 6'd1};
    vecs[2] = '{1'b0, 8'd7,  3, {15'h0000, 15'h0005, 15'h0004, 15'h0003}, 1'b0, 6'd3, 6'd0, 6'd0};
    vecs[3] = '{1'b0, 8'd8,  1, {15'h0000, 15'h0000, 15'h0000, 15'h1234}, 1'b1, 6'd1, 6'd1, 6'd0};
    vecs[4] = '{1'b1, 8'd9,  3, {15'h0000, 15'h1234, 15'h0001, 15'h1234}, 1'b1, 6'd1, 6'd1, 6'd0};
    vecs[5] = '{1'b1, 8'd10, 3, {15'h0000, 15'h0003, 15'h0002, 15'h0001}, 1'b0, 6'd3, 6'd0, 6'd0};
    vecs[6] = '{1'b1, 8'd11, 2, {15'h0000, 15'h0000, 15'h1234, 15'h0001}, 1'b1, 6'd2, 6'd1, 6'd1};

    #3;
    check("reset outputs", {smp_ready, res_valid, res_id, res_mask, res_count, res_hits, res_first},
          {1'b1, 1'b0, 8'd0, 1'b0, 6'd0, 6'd0, 6'd0});
    tick();
    rst = 1'b0;
    tick();

    twrite(15'h1234, 1'b1);
    twrite(15'h0001, 1'b0);
    twrite(15'h0002, 1'b0);
    twrite(15'h0003, 1'b0);
    twrite(15'h0004, 1'b0);
    twrite(15'h0005, 1'b0);

    for (int v = 0; v < 7; v++) run_vec(v, 0);

    // Result backpressure for 10 cycles.
    run_vec(0, 10);

    // Saturation: 70 hitting beats.
    mode_early = 1'b0;
    for (int i = 0; i < 70; i++) beat(15'h1234, 8'h33, (i == 69), st);
    finish_edge("saturate", 8'h33, 1'b1, 6'd63, 6'd63, 6'd0, 0);

    // Table write attempted mid-edge must be dropped.
    beat(15'h0003, 8'h44, 1'b0, st);
    twrite(15'h0001, 1'b1);
    beat(15'h0003, 8'h44, 1'b1, st);
    finish_edge("we in scan", 8'h44, 1'b0, 6'd2, 6'd0, 6'd0, 0);
    beat(15'h0001, 8'h45, 1'b1, st);
    finish_edge("dropped write", 8'h45, 1'b0, 6'd1, 6'd0, 6'd0, 0);

    // Reset mid-scan after two beats.
    beat(15'h1234, 8'h66, 1'b0, st);
    beat(15'h1234, 8'h66, 1'b0, st);
    #2 rst = 1'b1;
    #1;
    check("async reset outputs", {smp_ready, res_valid, res_id, res_mask, res_count, res_hits, res_first},
          {1'b1, 1'b0, 8'd0, 1'b0, 6'd0, 6'd0, 6'd0});
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("no result after reset", res_valid, 1'b0);
    beat(15'h0002, 8'h77, 1'b1, st);
    finish_edge("post reset", 8'h77, 1'b0, 6'd1, 6'd0, 6'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
